// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM hazard sources in, pipeline hold/flush
// controls and statistics out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       insrsID;
    logic [4:0]       insrtID;
    logic             usesrtID;
    logic             MemReadEX;
    logic [4:0]       destEX;
    logic             branchtakenEX;
    logic             memwait;
    logic             holdPC;
    logic             holdIFID;
    logic             holdIDEX;
    logic             holdEXMEM;
    logic             flushIFID;
    logic             flushIDEX;
    logic [1:0]       state;
    logic [CNT_W-1:0] stallcnt;
    logic [CNT_W-1:0] flushcnt;
    logic             memtimeout;

    modport master (
        output insrsID, insrtID, usesrtID, MemReadEX, destEX, branchtakenEX, memwait,
        input  holdPC, holdIFID, holdIDEX, holdEXMEM, flushIFID, flushIDEX,
        input  state, stallcnt, flushcnt, memtimeout
    );

    modport slave (
        input  insrsID, insrtID, usesrtID, MemReadEX, destEX, branchtakenEX, memwait,
        output holdPC, holdIFID, holdIDEX, holdEXMEM, flushIFID, flushIDEX,
        output state, stallcnt, flushcnt, memtimeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage CPU: load-use stalls, taken-branch
// flushes and data-memory waits, with saturating statistics and a timeout flag.
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 64
) (
    input logic        clk,
    input logic        reset,
    hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM    = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LIM_M1 = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDUSE = 2'd1,
        FLUSH = 2'd2,
        MEMWT = 2'd3
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic              load_use;
    logic              hold_pc;
    logic              hold_ifid;
    logic              hold_idex;
    logic              hold_exmem;
    logic              flush_ifid;
    logic              flush_idex;
    logic              branch_flush;
    logic              stall_event;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_timeout;

    always_comb begin
        load_use = hz.MemReadEX && (hz.destEX != 5'd0) &&
                   ((hz.destEX == hz.insrsID) || (hz.usesrtID && (hz.destEX == hz.insrtID)));
    end

    // Memory wait dominates everywhere; the full hazard decision only runs in RUN
    // and on MEMWT release, since LDUSE/FLUSH already have a bubble in flight.
    always_comb begin
        next_state   = RUN;
        hold_pc      = 1'b0;
        hold_ifid    = 1'b0;
        hold_idex    = 1'b0;
        hold_exmem   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        branch_flush = 1'b0;
        if (!reset) begin
            if (hz.memwait) begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
                next_state = MEMWT;
            end else if (cur_state == RUN || cur_state == MEMWT) begin
                if (hz.branchtakenEX) begin
                    flush_ifid   = 1'b1;
                    flush_idex   = 1'b1;
                    branch_flush = 1'b1;
                    next_state   = FLUSH;
                end else if (load_use) begin
                    hold_pc    = 1'b1;
                    hold_ifid  = 1'b1;
                    flush_idex = 1'b1;
                    next_state = LDUSE;
                end
            end
        end
    end

    assign stall_event = hold_pc | hold_ifid | hold_idex | hold_exmem | flush_idex;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (stall_event && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            // Timeout fires on the edge where the consecutive count reaches WAIT_MAX.
            if (hz.memwait) begin
                if (wait_cnt != WAIT_LIM) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= WAIT_LIM_M1) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign hz.holdPC     = hold_pc;
    assign hz.holdIFID   = hold_ifid;
    assign hz.holdIDEX   = hold_idex;
    assign hz.holdEXMEM  = hold_exmem;
    assign hz.flushIFID  = flush_ifid;
    assign hz.flushIDEX  = flush_idex;
    assign hz.state      = cur_state;
    assign hz.stallcnt   = stall_cnt;
    assign hz.flushcnt   = flush_cnt;
    assign hz.memtimeout = mem_timeout;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters (CNT_W=4) and a short
// memory timeout (WAIT_MAX=4) so saturation and timeout are reachable quickly.
module tb_hazard_ctrl;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;

    // Control vector order: {holdPC, holdIFID, holdIDEX, holdEXMEM, flushIFID, flushIDEX}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_HOLD = 6'b111100;
    localparam logic [5:0] C_LDU  = 6'b110001;
    localparam logic [5:0] C_BR   = 6'b000011;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ctl();
        return {bus.holdPC, bus.holdIFID, bus.holdIDEX, bus.holdEXMEM, bus.flushIFID, bus.flushIDEX};
    endfunction

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                                 input logic memread, input logic [4:0] dest,
                                 input logic br, input logic mw);
        bus.insrsID       = rs;
        bus.insrtID       = rt;
        bus.usesrtID      = usesrt;
        bus.MemReadEX     = memread;
        bus.destEX        = dest;
        bus.branchtakenEX = br;
        bus.memwait       = mw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        // Reset with memwait asserted: controls must stay low.
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        checkOutput("reset_ctl_gated", 32'(ctl()), 32'(C_NONE));
        tick();
        tick();
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_stallcnt", 32'(bus.stallcnt), 32'd0);
        checkOutput("reset_flushcnt", 32'(bus.flushcnt), 32'd0);
        checkOutput("reset_timeout", 32'(bus.memtimeout), 32'd0);
        reset = 1'b0;
        idle();
        checkOutput("run_idle_ctl", 32'(ctl()), 32'(C_NONE));

        // Load-use on rs, inputs kept during LDUSE to show no re-check there.
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        checkOutput("lu_rs_ctl", 32'(ctl()), 32'(C_LDU));
        tick();
        checkOutput("lu_state_lduse", 32'(bus.state), 32'd1);
        checkOutput("lu_lduse_ctl", 32'(ctl()), 32'(C_NONE));
        checkOutput("lu_stallcnt", 32'(bus.stallcnt), 32'd1);
        idle();
        tick();
        checkOutput("lu_back_run", 32'(bus.state), 32'd0);
        checkOutput("lu_stallcnt_hold", 32'(bus.stallcnt), 32'd1);

        // Benign patterns.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        checkOutput("benign_r0", 32'(ctl()), 32'(C_NONE));
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
        checkOutput("benign_noload", 32'(ctl()), 32'(C_NONE));
        applyStimulus(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        checkOutput("benign_rt_unused", 32'(ctl()), 32'(C_NONE));
        applyStimulus(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        checkOutput("lu_rt_ctl", 32'(ctl()), 32'(C_LDU));
        tick();
        checkOutput("lu_rt_state", 32'(bus.state), 32'd1);
        checkOutput("lu_rt_stallcnt", 32'(bus.stallcnt), 32'd2);
        // Memory wait arriving in LDUSE still holds everything.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("lduse_memwait_ctl", 32'(ctl()), 32'(C_HOLD));
        tick();
        checkOutput("lduse_to_memwt", 32'(bus.state), 32'd3);
        idle();
        checkOutput("memwt_release_idle", 32'(ctl()), 32'(C_NONE));
        tick();
        checkOutput("memwt_to_run", 32'(bus.state), 32'd0);
        checkOutput("stallcnt_after_wait", 32'(bus.stallcnt), 32'd3);

        // Branch coincident with load-use: branch wins, load-use discarded.
        doReset();
        applyStimulus(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        checkOutput("br_ctl", 32'(ctl()), 32'(C_BR));
        tick();
        checkOutput("br_state_flush", 32'(bus.state), 32'd2);
        checkOutput("br_flushcnt", 32'(bus.flushcnt), 32'd1);
        checkOutput("br_stallcnt", 32'(bus.stallcnt), 32'd1);
        checkOutput("flush_ignores_inputs", 32'(ctl()), 32'(C_NONE));
        tick();
        checkOutput("flush_to_run", 32'(bus.state), 32'd0);
        checkOutput("flushcnt_hold", 32'(bus.flushcnt), 32'd1);

        // Three-cycle memory wait released with a taken branch.
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            checkOutput("mw_hold_ctl", 32'(ctl()), 32'(C_HOLD));
            tick();
            checkOutput("mw_state", 32'(bus.state), 32'd3);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        checkOutput("mw_release_br_ctl", 32'(ctl()), 32'(C_BR));
        checkOutput("mw_stallcnt", 32'(bus.stallcnt), 32'd3);
        checkOutput("mw_no_timeout", 32'(bus.memtimeout), 32'd0);
        tick();
        checkOutput("mw_release_flush", 32'(bus.state), 32'd2);
        checkOutput("mw_release_flushcnt", 32'(bus.flushcnt), 32'd1);

        // Timeout: sets on the 4th consecutive edge, sticky after release.
        doReset();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            tick();
            checkOutput("to_flag", 32'(bus.memtimeout), (i >= 4) ? 32'd1 : 32'd0);
        end
        idle();
        tick();
        checkOutput("to_sticky", 32'(bus.memtimeout), 32'd1);
        checkOutput("to_state_run", 32'(bus.state), 32'd0);
        checkOutput("to_stallcnt", 32'(bus.stallcnt), 32'd6);

        // Reset in MEMWT with memwait still high.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        checkOutput("pre_reset_memwt", 32'(bus.state), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_ctl", 32'(ctl()), 32'(C_NONE));
        tick();
        checkOutput("reset_mid_state", 32'(bus.state), 32'd0);
        checkOutput("reset_mid_stallcnt", 32'(bus.stallcnt), 32'd0);
        checkOutput("reset_mid_timeout", 32'(bus.memtimeout), 32'd0);
        reset = 1'b0;

        // A gap in memwait restarts the consecutive count.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("gap_no_timeout", 32'(bus.memtimeout), 32'd0);
        tick();
        checkOutput("gap_fourth_edge", 32'(bus.memtimeout), 32'd1);

        // Saturation: 20 load-use stalls on a 4-bit counter.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
            tick();
            idle();
            tick();
        end
        checkOutput("sat_stallcnt", 32'(bus.stallcnt), 32'd15);
        checkOutput("sat_flushcnt", 32'(bus.flushcnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Drives the hold and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Keeps saturating stall/flush statistics and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of stallcnt and flushcnt
WAIT_MAX, 64, memwait cycles (consecutive) after which memtimeout sets; must be >=1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
insrsID  input  5  rs field of instruction in ID
insrtID  input  5  rt field of instruction in ID
usesrtID  input  1  ID instruction reads rt (R-type, beq, bne, sw)
MemReadEX  input  1  EX instruction is a load
destEX  input  5  EX destination register (after RegDst mux)
branchtakenEX  input  1  beq/bne in EX resolved taken
memwait  input  1  data memory not ready; MEM access must be held
holdPC  output  1  freeze PC
holdIFID  output  1  freeze IF/ID
holdIDEX  output  1  freeze ID/EX
holdEXMEM  output  1  freeze EX/MEM
flushIFID  output  1  synchronous clear of IF/ID next edge
flushIDEX  output  1  synchronous clear of ID/EX next edge (bubble)
state  output  2  FSM state: 0 RUN, 1 LDUSE, 2 FLUSH, 3 MEMWT
stallcnt  output  CNT_W  cycles with any hold or flushIDEX asserted
flushcnt  output  CNT_W  taken-branch flush events
memtimeout  output  1  sticky: memwait exceeded WAIT_MAX

Behaviour:
- State, counters and memtimeout are registered. Control outputs are combinational from the current state and inputs (Mealy), so a stall takes effect the same cycle.
- Reset (sync, high):
  - next state RUN; stallcnt=0, flushcnt=0, memtimeout=0, wait counter=0.
  - While reset=1, all hold/flush outputs are 0; pipe registers have their own reset.
  - Reset mid-stall aborts the stall and returns to RUN at the next edge.
- loaduse = MemReadEX && destEX!=0 && (destEX==insrsID || (usesrtID && destEX==insrtID)).
- Decision priority, used in RUN and in MEMWT when memwait=0:
  1. memwait=1: all four holds=1, flushes=0; next MEMWT.
  2. Else branchtakenEX=1: flushIFID=1, flushIDEX=1, holds=0; next FLUSH; flushcnt+1.
  3. Else loaduse=1: holdPC=1, holdIFID=1, flushIDEX=1, holdIDEX=0, holdEXMEM=0; next LDUSE.
  4. Else all outputs 0; next RUN.
- LDUSE (one cycle; bubble now in EX):
  - memwait=1: all four holds=1; next MEMWT.
  - Otherwise: outputs 0, no hazard check; next RUN.
- FLUSH (one cycle; IF/ID holds a bubble):
  - memwait=1: all four holds=1; next MEMWT.
  - Otherwise: outputs 0, no loaduse check; next RUN.
  - A new branchtakenEX is impossible here (EX holds a bubble) and is ignored.
- MEMWT:
  - memwait=1: all four holds=1; stay in MEMWT.
  - memwait=0: full RUN decision in the same cycle. A branch or load-use frozen in EX during the wait is therefore handled on release.
- Wait counter:
  - Counts consecutive cycles with memwait=1; clears when memwait=0.
  - On reaching WAIT_MAX, memtimeout sets and stays set until reset.
  - The counter saturates at WAIT_MAX.
- stallcnt: +1 on each clock edge where any hold or flushIDEX was 1. Saturates at all ones, no wrap.
- flushcnt: +1 per branch flush event. Saturates at all ones.
- Simultaneous events: memwait dominates, then branch, then load-use. A load-use coincident with a taken branch is discarded because the ID instruction is flushed.

Test Plan:
- Load-use: MemReadEX=1, destEX=5, insrsID=5 in RUN -> same cycle holdPC=holdIFID=flushIDEX=1; next cycle state=1, outputs 0; then RUN; stallcnt=1.
- Benign cases:
  - destEX=0, insrsID=0, MemReadEX=1 -> no stall.
  - insrtID=5, usesrtID=0 -> no stall.
  - insrtID=5, usesrtID=1 -> stall.
- Branch: branchtakenEX=1 together with loaduse=1 -> flushIFID=flushIDEX=1, holds=0; next state=2; flushcnt=1; next cycle all outputs 0.
- Memory wait: memwait=1 for 3 cycles -> all four holds=1 for 3 cycles, state=3. Release cycle with branchtakenEX=1 -> flushes=1, state goes to 2; stallcnt=3.
- Timeout: WAIT_MAX=4, memwait held 6 cycles -> memtimeout=1 after the 4th edge and stays 1 after memwait drops; reset clears it.
- Reset mid-MEMWT with memwait=1 -> outputs 0 during reset; state=0 and counters 0 after the edge.
- Saturation: CNT_W=4, 20 load-use stalls -> stallcnt=15.
